// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mem_pkg
// Brief   : Shared FSM encoding, default widths and counter helpers for the
//           CPU-side memory responder.
// Revision: 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

    localparam int c_default_addr_width   = 8;
    localparam int c_default_data_width   = 16;
    localparam int c_default_read_latency = 2;

    // Wide enough to hold READ_LATENCY-1 for the maximum latency of 7.
    localparam int                   c_cnt_width    = 3;
    localparam logic [c_cnt_width-1:0] c_cnt_one    = c_cnt_width'(1);
    localparam int                   c_write_cycles = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [c_cnt_width-1:0] cnt_load(input int cycles);
        return c_cnt_width'(cycles - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array_sp.sv
`default_nettype none
// ============================================================================
// Module  : mem_array_sp
// Brief   : Single-port storage array, synchronous write, registered read.
//           Contents are never reset.
// Revision: 1.0 - initial release
// ============================================================================
module mem_array_sp #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem_q [c_depth];
    logic [DATA_WIDTH-1:0] r_rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem_q[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_q <= r_mem_q[i_addr];
        end
    end

    assign o_rdata = r_rdata_q;

endmodule
`default_nettype wire

// File: rtl/memory_responder.sv
`default_nettype none
// ============================================================================
// Module  : memory_responder
// Brief   : Request FSM, address/data latches and latency counter in front of
//           a single-port array; one request in flight at a time.
// Revision: 1.0 - initial release
// ============================================================================
module memory_responder
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_WIDTH   = c_default_addr_width,
    parameter int DATA_WIDTH   = c_default_data_width,
    parameter int READ_LATENCY = c_default_read_latency
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_mar_address_bus,
    input  logic [DATA_WIDTH-1:0] i_mbr_data_bus,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    output logic [DATA_WIDTH-1:0] o_mem_data_bus,
    output logic                  o_mem_ready,
    output logic                  o_mem_busy,
    output logic                  o_mem_err
);

    state_e                 r_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0]  r_addr_q,  w_addr_d;
    logic [DATA_WIDTH-1:0]  r_wdata_q, w_wdata_d;
    logic [DATA_WIDTH-1:0]  r_rdata_q, w_rdata_d;
    logic [c_cnt_width-1:0] r_cnt_q,   w_cnt_d;
    logic                   r_ready_q, w_ready_d;
    logic                   r_busy_q,  w_busy_d;
    logic                   r_err_q,   w_err_d;

    logic                   w_idle;
    logic                   w_accept_rd;
    logic                   w_accept_wr;
    logic                   w_conflict;
    logic                   w_arr_we;
    logic                   w_arr_re;
    logic [ADDR_WIDTH-1:0]  w_arr_addr;
    logic [DATA_WIDTH-1:0]  w_arr_rdata;

    assign w_idle      = (r_state_q == ST_IDLE);
    assign w_accept_rd = w_idle &&  i_mem_read && !i_mem_write;
    assign w_accept_wr = w_idle && !i_mem_read &&  i_mem_write;
    assign w_conflict  = w_idle &&  i_mem_read &&  i_mem_write;

    // The array is read at the acceptance edge straight from the bus so that a
    // latency of 1 already has valid array data when the counter reaches 0.
    assign w_arr_addr = w_idle ? i_mar_address_bus : r_addr_q;
    assign w_arr_re   = w_accept_rd || (r_state_q == ST_READ);
    // Commit happens on the edge that leaves WRITE; a reset on that edge wins.
    assign w_arr_we   = (r_state_q == ST_WRITE) && (r_cnt_q == '0) && !i_rst;

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_cnt_d   = r_cnt_q;
        w_rdata_d = '0;
        w_ready_d = 1'b0;
        w_err_d   = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept_rd) begin
                    w_addr_d  = i_mar_address_bus;
                    w_cnt_d   = cnt_load(READ_LATENCY);
                    w_state_d = ST_READ;
                end else if (w_accept_wr) begin
                    w_addr_d  = i_mar_address_bus;
                    w_wdata_d = i_mbr_data_bus;
                    w_cnt_d   = cnt_load(c_write_cycles);
                    w_state_d = ST_WRITE;
                end else if (w_conflict) begin
                    w_err_d   = 1'b1;
                end
            end
            ST_READ: begin
                if (r_cnt_q == '0) begin
                    w_rdata_d = w_arr_rdata;
                    w_ready_d = 1'b1;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - c_cnt_one;
                end
            end
            ST_WRITE: begin
                if (r_cnt_q == '0) begin
                    w_ready_d = 1'b1;
                    w_state_d = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - c_cnt_one;
                end
            end
            ST_DONE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= ST_IDLE;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
            r_cnt_q   <= '0;
            r_ready_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
            r_cnt_q   <= w_cnt_d;
            r_ready_q <= w_ready_d;
            r_busy_q  <= w_busy_d;
            r_err_q   <= w_err_d;
        end
    end

    mem_array_sp #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (w_arr_we),
        .i_re    (w_arr_re),
        .i_addr  (w_arr_addr),
        .i_wdata (r_wdata_q),
        .o_rdata (w_arr_rdata)
    );

    assign o_mem_data_bus = r_rdata_q;
    assign o_mem_ready    = r_ready_q;
    assign o_mem_busy     = r_busy_q;
    assign o_mem_err      = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_responder
// Brief   : Three responders (read latency 1, 2, 7) share one request stream;
//           a reference array model predicts every ready/err pulse.
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_responder;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] data_bus [3];
    logic        ready    [3];
    logic        busy     [3];
    logic        err      [3];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] model [256];
    exp_t        sb [3][$];
    int          eq [3][$];
    exp_t        mon_e;
    int          mon_c;

    function automatic int lat(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 7;
        endcase
    endfunction

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(1)) u_dut_l1 (
        .i_clk(clk), .i_rst(rst), .i_mar_address_bus(addr), .i_mbr_data_bus(wdata),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .o_mem_data_bus(data_bus[0]),
        .o_mem_ready(ready[0]), .o_mem_busy(busy[0]), .o_mem_err(err[0]));

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(2)) u_dut_l2 (
        .i_clk(clk), .i_rst(rst), .i_mar_address_bus(addr), .i_mbr_data_bus(wdata),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .o_mem_data_bus(data_bus[1]),
        .o_mem_ready(ready[1]), .o_mem_busy(busy[1]), .o_mem_err(err[1]));

    memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .READ_LATENCY(7)) u_dut_l7 (
        .i_clk(clk), .i_rst(rst), .i_mar_address_bus(addr), .i_mbr_data_bus(wdata),
        .i_mem_read(mem_read), .i_mem_write(mem_write), .o_mem_data_bus(data_bus[2]),
        .o_mem_ready(ready[2]), .o_mem_busy(busy[2]), .o_mem_err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int k, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, got, want);
        end
    endtask

    // Monitor: every ready/err pulse must match the head of its queue.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ready[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    check("ready_unexpected", k, 32'(ready[k]), 32'd0);
                end else begin
                    mon_e = sb[k].pop_front();
                    check("ready_cycle", k, cyc, mon_e.cyc);
                    check("ready_data", k, 32'(data_bus[k]), 32'(mon_e.data));
                    check("busy_in_done", k, 32'(busy[k]), 32'd1);
                end
            end else begin
                check("data_idle_zero", k, 32'(data_bus[k]), 32'd0);
            end
            if (err[k] === 1'b1) begin
                if (eq[k].size() == 0) begin
                    check("err_unexpected", k, 32'(err[k]), 32'd0);
                end else begin
                    mon_c = eq[k].pop_front();
                    check("err_cycle", k, cyc, mon_c);
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!busy[0] && !busy[1] && !busy[2]) return;
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL idle_timeout cyc=%0d got busy=%0b%0b%0b want 000", cyc,
                 busy[0], busy[1], busy[2]);
    endtask

    task automatic pulse_reset(input int len);
        rst = 1'b1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                check("rst_data", k, 32'(data_bus[k]), 32'd0);
                check("rst_ready", k, 32'(ready[k]), 32'd0);
                check("rst_busy", k, 32'(busy[k]), 32'd0);
                check("rst_err", k, 32'(err[k]), 32'd0);
            end
        end
        rst = 1'b0;
    endtask

    // Called at a negedge with all responders idle; the next posedge accepts.
    // rst_after > 0 asserts reset that many negedges after the strobe, so no
    // completion is expected and the model is left untouched.
    task automatic issue(input bit rd, input bit wr, input logic [7:0] a,
                         input logic [15:0] d, input int rst_after, input int rst_len);
        exp_t e;
        int   c;
        c         = cyc;
        addr      = a;
        wdata     = d;
        mem_read  = rd;
        mem_write = wr;
        if (rst_after == 0) begin
            for (int k = 0; k < 3; k++) begin
                if (rd && !wr) begin
                    e.cyc = c + 1 + lat(k); e.data = model[a]; sb[k].push_back(e);
                end else if (wr && !rd) begin
                    e.cyc = c + 3; e.data = 16'h0; sb[k].push_back(e);
                end else if (rd && wr) begin
                    eq[k].push_back(c + 1);
                end
            end
            if (wr && !rd) model[a] = d;
        end
        @(negedge clk);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 8'($urandom);
        wdata     = 16'($urandom);
        if (rd && wr) begin
            for (int k = 0; k < 3; k++) check("conflict_busy", k, 32'(busy[k]), 32'd0);
        end
        if (rst_after > 0) begin
            repeat (rst_after - 1) @(negedge clk);
            pulse_reset(rst_len);
        end
        wait_idle();
    endtask

    initial begin
        bit rd;
        int kind;
        rst       = 1'b1;
        addr      = '0;
        wdata     = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pulse_reset(3);

        for (int a = 0; a < 256; a++) issue(1'b0, 1'b1, 8'(a), 16'($urandom), 0, 0);

        // Write-then-read, including both ends of the address range.
        issue(1'b0, 1'b1, 8'h10, 16'hBEEF, 0, 0);
        issue(1'b1, 1'b0, 8'h10, 16'h0000, 0, 0);
        issue(1'b0, 1'b1, 8'h00, 16'hA5A5, 0, 0);
        issue(1'b0, 1'b1, 8'hFF, 16'h5A5A, 0, 0);
        issue(1'b1, 1'b0, 8'h00, 16'h0000, 0, 0);
        issue(1'b1, 1'b0, 8'hFF, 16'h0000, 0, 0);

        // Conflicting strobes: error only, contents unchanged.
        issue(1'b1, 1'b1, 8'h05, 16'hDEAD, 0, 0);
        issue(1'b1, 1'b0, 8'h05, 16'h0000, 0, 0);

        // Reset during WRITE (both cycles) suppresses the commit.
        issue(1'b0, 1'b1, 8'h20, 16'h1234, 2, 1);
        issue(1'b1, 1'b0, 8'h20, 16'h0000, 0, 0);
        issue(1'b0, 1'b1, 8'h20, 16'h4321, 1, 1);
        issue(1'b1, 1'b0, 8'h20, 16'h0000, 0, 0);

        // Second read strobe while busy is ignored.
        begin
            exp_t e;
            addr = 8'h00; mem_read = 1'b1;
            for (int k = 0; k < 3; k++) begin
                e.cyc = cyc + 1 + lat(k); e.data = model[8'h00]; sb[k].push_back(e);
            end
            @(negedge clk);
            addr = 8'hFF;
            @(negedge clk);
            mem_read = 1'b0;
            wait_idle();
        end

        // Reset wins over a write strobe in the same cycle.
        rst = 1'b1; addr = 8'h30; wdata = ~model[8'h30]; mem_write = 1'b1;
        @(negedge clk);
        mem_write = 1'b0;
        pulse_reset(1);
        wait_idle();
        issue(1'b1, 1'b0, 8'h30, 16'h0000, 0, 0);

        // Reset held three cycles during a read, then traffic resumes.
        issue(1'b1, 1'b0, 8'h40, 16'h0000, 1, 3);
        issue(1'b1, 1'b0, 8'h40, 16'h0000, 0, 0);

        for (int i = 0; i < 200; i++) begin
            kind = int'($urandom_range(0, 19));
            if (kind < 9)       issue(1'b1, 1'b0, 8'($urandom), 16'($urandom), 0, 0);
            else if (kind < 18) issue(1'b0, 1'b1, 8'($urandom), 16'($urandom), 0, 0);
            else if (kind == 18) issue(1'b1, 1'b1, 8'($urandom), 16'($urandom), 0, 0);
            else begin
                rd = 1'($urandom_range(0, 1));
                issue(rd, !rd, 8'($urandom), 16'($urandom),
                      rd ? 1 : int'($urandom_range(1, 2)), int'($urandom_range(1, 3)));
            end
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("ready_drain", k, 32'(sb[k].size()), 32'd0);
            check("err_drain", k, 32'(eq[k].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
